// File: rtl/i2s_audio_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_audio_rx
// Description : I2S receiver for a single microphone slot. The asynchronous
//               I2S bit clock, word select and data are synchronised into the
//               clk domain, the selected slot is shifted in MSB-first and the
//               finished sample is presented to the KWS accelerator with a
//               one-clk valid pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active low
//   enable       in   capture enable (level)
//   i2s_sck      in   asynchronous I2S bit clock
//   i2s_ws       in   asynchronous I2S word select
//   i2s_sd       in   asynchronous I2S serial data
//   err_clr      in   clears short_err
//   audio_sample out  last captured two's-complement sample
//   sample_valid out  one-clk pulse when audio_sample updates
//   sample_count out  samples delivered, wraps at 16 bits
//   short_err    out  sticky: slot ended before SAMPLE_BITS bits arrived
// ============================================================================
module i2s_audio_rx #(
    parameter int SAMPLE_BITS = 16,   // must be >= 2
    parameter int CHANNEL     = 0     // 0 = left (ws low), 1 = right (ws high)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   i2s_sck,
    input  logic                   i2s_ws,
    input  logic                   i2s_sd,
    input  logic                   err_clr,
    output logic [SAMPLE_BITS-1:0] audio_sample,
    output logic                   sample_valid,
    output logic [15:0]            sample_count,
    output logic                   short_err
);

    localparam int               CNT_W     = $clog2(SAMPLE_BITS + 1);
    localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(SAMPLE_BITS);
    localparam logic             C_SLOT_WS = (CHANNEL != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // Synchronisers; the third sck flop only serves edge detection.
    logic                   r_sck_s1, r_sck_s2, r_sck_s3;
    logic                   r_ws_s1,  r_ws_s2;
    logic                   r_sd_s1,  r_sd_s2;
    logic                   r_ws_prev;

    logic [CNT_W-1:0]       r_cnt,   w_cnt_nxt;
    logic [SAMPLE_BITS-1:0] r_shreg, w_shreg_nxt;

    logic [SAMPLE_BITS-1:0] r_audio;
    logic                   r_valid;
    logic [15:0]            r_count;
    logic                   r_err;

    logic                   w_sck_rise;
    logic                   w_ws_edge;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   w_load;
    logic                   w_set_err;

    assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
    assign w_ws_edge  = w_sck_rise & (r_ws_s2 ^ r_ws_prev);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_load      = 1'b0;
        w_set_err   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (enable) begin
                    w_state_nxt = S_ALIGN;
                end
            end

            S_ALIGN: begin
                // The sck-rise that reveals the new ws still carries the last
                // bit of the previous slot; the MSB comes on the next rise.
                if (w_ws_edge && (r_ws_s2 == C_SLOT_WS)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (r_cnt == C_FULL) begin
                    // Word complete: publish it one clk after the last shift.
                    w_load      = 1'b1;
                    w_state_nxt = S_ALIGN;
                end else if (w_sck_rise) begin
                    w_shreg_nxt = {r_shreg[SAMPLE_BITS-2:0], r_sd_s2};
                    w_cnt_nxt   = w_cnt_inc;
                    // A ws-edge together with the final bit is a full word.
                    if (w_ws_edge && (w_cnt_inc != C_FULL)) begin
                        w_set_err   = 1'b1;
                        w_state_nxt = S_ALIGN;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Disable overrides everything: partial word dropped, no pulse.
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_load      = 1'b0;
            w_set_err   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_s3  <= 1'b0;
            r_ws_s1   <= 1'b0;
            r_ws_s2   <= 1'b0;
            r_sd_s1   <= 1'b0;
            r_sd_s2   <= 1'b0;
            r_ws_prev <= 1'b0;
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_audio   <= '0;
            r_valid   <= 1'b0;
            r_count   <= 16'd0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sck_s1  <= i2s_sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_s3  <= r_sck_s2;
            r_ws_s1   <= i2s_ws;
            r_ws_s2   <= r_ws_s1;
            r_sd_s1   <= i2s_sd;
            r_sd_s2   <= r_sd_s1;
            if (w_sck_rise) begin
                r_ws_prev <= r_ws_s2;
            end
            r_cnt     <= w_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_valid   <= w_load;
            if (w_load) begin
                r_audio <= r_shreg;
                r_count <= r_count + 16'd1;
            end
            // A new error in the same clk as err_clr must remain visible.
            if (w_set_err) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign audio_sample = r_audio;
    assign sample_valid = r_valid;
    assign sample_count = r_count;
    assign short_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_audio_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_audio_rx
// Description : Directed bench for i2s_audio_rx (SAMPLE_BITS=16, CHANNEL=0)
//               with 32-bit stereo slots and sck = clk/8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_audio_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        i2s_sck = 1'b0;
    logic        i2s_ws = 1'b0;
    logic        i2s_sd = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] audio_sample;
    logic        sample_valid;
    logic [15:0] sample_count;
    logic        short_err;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int pulses = 0;
    int last_valid_cyc = -1;
    int rise16_cyc = -1;
    logic seen_7fff = 1'b0;
    logic prev_valid = 1'b0;

    i2s_audio_rx #(
        .SAMPLE_BITS (16),
        .CHANNEL     (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .i2s_sck      (i2s_sck),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .err_clr      (err_clr),
        .audio_sample (audio_sample),
        .sample_valid (sample_valid),
        .sample_count (sample_count),
        .short_err    (short_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (prev_valid) begin
            check("valid_single_clk", {31'd0, sample_valid}, 32'd0);
        end
        if (sample_valid) begin
            pulses++;
            last_valid_cyc = cyc;
            if (audio_sample === 16'h7FFF) seen_7fff = 1'b1;
        end
        prev_valid = sample_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One I2S slot: period 0 carries the trailing bit of the previous slot
    // (always 0 here), periods 1..nbits carry data MSB-first, the rest pad.
    // ws/sd change while sck is low, sck then rises for 4 clks.
    task automatic send_slot(input logic ws_v, input logic [15:0] data,
                             input int nbits, input int len, input int clr_k);
        logic [15:0] d;
        d = data;
        for (int k = 0; k < len; k++) begin
            i2s_sck = 1'b0;
            i2s_ws  = ws_v;
            i2s_sd  = (k >= 1 && k <= nbits) ? d[16-k] : 1'b0;
            repeat (4) tick();
            i2s_sck = 1'b1;
            if (k == 16 && ws_v == 1'b0) rise16_cyc = cyc;
            tick();
            tick();
            if (k == clr_k) err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            tick();
        end
    endtask

    task automatic send_frame(input logic [15:0] left, input logic [15:0] right);
        send_slot(1'b0, left, 16, 32, -1);
        send_slot(1'b1, right, 16, 32, -1);
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (5) tick();
        check("rst_audio",  {16'd0, audio_sample}, 32'd0);
        check("rst_valid",  {31'd0, sample_valid}, 32'd0);
        check("rst_count",  {16'd0, sample_count}, 32'd0);
        check("rst_err",    {31'd0, short_err},    32'd0);
        rst = 1'b1;
        enable = 1'b1;
        repeat (2) tick();

        // ---------------- stereo frames 0x8001 / 0x7FFF ----------------
        send_slot(1'b1, 16'h7FFF, 16, 32, -1);
        send_frame(16'h8001, 16'h7FFF);
        send_frame(16'h8001, 16'h7FFF);
        send_frame(16'h8001, 16'h7FFF);
        check("frames_pulses", pulses, 32'd3);
        check("frames_audio",  {16'd0, audio_sample}, 32'h8001);
        check("frames_count",  {16'd0, sample_count}, 32'd3);
        check("latency",       last_valid_cyc, rise16_cyc + 4);
        check("no_right",      {31'd0, seen_7fff}, 32'd0);
        check("frames_err",    {31'd0, short_err}, 32'd0);

        // ---------------- short slot ----------------
        send_slot(1'b0, 16'h1234, 10, 11, -1);
        send_slot(1'b1, 16'h7FFF, 16, 32, -1);
        check("short_err_set",  {31'd0, short_err}, 32'd1);
        check("short_pulses",   pulses, 32'd3);
        check("short_audio",    {16'd0, audio_sample}, 32'h8001);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        check("err_clr", {31'd0, short_err}, 32'd0);

        // second short slot, err_clr in the same clk as the set event
        send_slot(1'b0, 16'h4321, 10, 11, -1);
        send_slot(1'b1, 16'h7FFF, 16, 32, 0);
        check("set_beats_clr", {31'd0, short_err}, 32'd1);
        check("short2_pulses", pulses, 32'd3);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();

        // ---------------- enable dropped mid-word ----------------
        send_slot(1'b0, 16'hA5A5, 8, 9, -1);
        enable = 1'b0;
        repeat (3) tick();
        check("dis_pulses", pulses, 32'd3);
        check("dis_audio",  {16'd0, audio_sample}, 32'h8001);
        check("dis_count",  {16'd0, sample_count}, 32'd3);
        enable = 1'b1;
        send_slot(1'b1, 16'h7FFF, 16, 32, -1);
        send_frame(16'h5A3C, 16'h7FFF);
        check("reen_pulses", pulses, 32'd4);
        check("reen_audio",  {16'd0, audio_sample}, 32'h5A3C);
        check("reen_count",  {16'd0, sample_count}, 32'd4);
        check("reen_err",    {31'd0, short_err}, 32'd0);

        // ---------------- sample_count wrap ----------------
        force dut.r_count = 16'hFFFF;
        tick();
        release dut.r_count;
        tick();
        check("preload", {16'd0, sample_count}, 32'hFFFF);
        send_frame(16'h0F0F, 16'h7FFF);
        check("wrap_count",  {16'd0, sample_count}, 32'h0000);
        check("wrap_audio",  {16'd0, audio_sample}, 32'h0F0F);
        check("wrap_pulses", pulses, 32'd5);

        // ---------------- reset mid-SHIFT ----------------
        send_slot(1'b0, 16'h1357, 8, 9, -1);
        rst = 1'b0;
        tick();
        check("mid_rst_audio", {16'd0, audio_sample}, 32'd0);
        check("mid_rst_valid", {31'd0, sample_valid}, 32'd0);
        check("mid_rst_count", {16'd0, sample_count}, 32'd0);
        check("mid_rst_err",   {31'd0, short_err},    32'd0);
        rst = 1'b1;
        tick();
        // left slot without a fresh ws-edge must not be captured
        send_slot(1'b0, 16'h1111, 16, 32, -1);
        check("post_rst_noedge", pulses, 32'd5);
        check("post_rst_count0", {16'd0, sample_count}, 32'd0);
        send_slot(1'b1, 16'h7FFF, 16, 32, -1);
        send_slot(1'b0, 16'h2468, 16, 32, -1);
        check("post_rst_pulses", pulses, 32'd6);
        check("post_rst_audio",  {16'd0, audio_sample}, 32'h2468);
        check("post_rst_count",  {16'd0, sample_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
